// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-cycle 16-bit shift controller (pass/ROR/ASR/RRC) with start/busy/done handshake
// Optional result flags Z/N are built only when SHIFT_SEQ_FLAGS_EN is defined.
module shift_sequencer (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [3:0]  amount,
   input  logic [15:0] A,
   input  logic        C_in,
   output logic [15:0] Y,
   output logic        C_out,
   output logic        busy,
   output logic        done
`ifdef SHIFT_SEQ_FLAGS_EN
   ,
   output logic        Z,
   output logic        N
`endif
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam logic [1:0] OP_PASS = 2'b00;
   localparam logic [1:0] OP_ROR  = 2'b01;
   localparam logic [1:0] OP_ASR  = 2'b10;
   localparam logic [1:0] OP_RRC  = 2'b11;

   logic [1:0]  state;
   logic [1:0]  op_q;
   logic [15:0] acc;
   logic        cf;
   logic [3:0]  cnt;

   logic [15:0] acc_step;
   logic        cf_step;

   // One single-position step of {cf, acc} for the latched operation.
   always_comb begin
      acc_step = acc;
      cf_step  = cf;
      case (op_q)
         OP_ROR:  acc_step = {acc[0], acc[15:1]};
         OP_ASR:  acc_step = {acc[15], acc[15:1]};
         OP_RRC: begin
            acc_step = {cf, acc[15:1]};
            cf_step  = acc[0];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         op_q  <= OP_PASS;
         acc   <= 16'h0000;
         cf    <= 1'b0;
         cnt   <= 4'd0;
      end else begin
         case (state)
            ST_SHIFT: begin
               acc <= acc_step;
               cf  <= cf_step;
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  state <= ST_DONE;
               end
            end
            default: begin
               // IDLE and DONE both accept a new request, so back-to-back starts see no bubble.
               if (start) begin
                  acc  <= A;
                  cf   <= C_in;
                  op_q <= op;
                  cnt  <= amount;
                  if ((amount == 4'd0) || (op == OP_PASS)) begin
                     state <= ST_DONE;
                  end else begin
                     state <= ST_SHIFT;
                  end
               end else begin
                  state <= ST_IDLE;
               end
            end
         endcase
      end
   end

   assign Y     = acc;
   assign C_out = cf;
   assign busy  = (state == ST_SHIFT);
   assign done  = (state == ST_DONE);

`ifdef SHIFT_SEQ_FLAGS_EN
   assign Z = (acc == 16'h0000);
   assign N = acc[15];
`endif

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - table-driven scoreboard bench for shift_sequencer
module tb_shift_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [3:0]  amount;
   logic [15:0] A;
   logic        C_in;
   logic [15:0] Y;
   logic        C_out;
   logic        busy;
   logic        done;
`ifdef SHIFT_SEQ_FLAGS_EN
   logic        Z;
   logic        N;
`endif

   shift_sequencer dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op),
      .amount (amount),
      .A      (A),
      .C_in   (C_in),
      .Y      (Y),
      .C_out  (C_out),
      .busy   (busy),
      .done   (done)
`ifdef SHIFT_SEQ_FLAGS_EN
      ,
      .Z      (Z),
      .N      (N)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [3:0]  amt;
      logic [15:0] a;
      logic        ci;
      logic [15:0] y;
      logic        c;
      int          gap;
      bit          noise;
   } vec_t;

   typedef struct {
      logic [15:0] y;
      logic        c;
      int          edges;
      int          busy_cnt;
   } exp_t;

   localparam int NV = 12;
   vec_t vecs [NV];
   exp_t sb [$];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   task automatic run_op(input vec_t v);
      exp_t e;
      int   edges;
      int   busy_cnt;
      chk("busy_before_start", busy, 1'b0);
      op     = v.op;
      amount = v.amt;
      A      = v.a;
      C_in   = v.ci;
      start  = 1'b1;
      @(posedge clk); #1;
      start  = 1'b0;
      e.y        = v.y;
      e.c        = v.c;
      e.edges    = ((v.op == 2'b00) || (v.amt == 4'd0)) ? 0 : int'(v.amt);
      e.busy_cnt = e.edges;
      sb.push_back(e);
      edges    = 0;
      busy_cnt = 0;
      while (!done && edges < 40) begin
         if (busy) busy_cnt++;
         start = v.noise && (edges == 1 || edges == 2);
         if (start) begin
            A      = 16'hDEAD;
            op     = 2'b10;
            amount = 4'd1;
            C_in   = ~v.ci;
         end
         @(posedge clk); #1;
         edges++;
      end
      start = 1'b0;
      e = sb.pop_front();
      if (!done) begin
         n_checks++;
         n_fail++;
         $display("FAIL done_timeout: got no done after %0d edges, required %0d", edges, e.edges);
      end else begin
         chk("result_Y", Y, e.y);
         chk("result_C_out", C_out, e.c);
         chk("done_latency", edges, e.edges);
         chk("busy_cycles", busy_cnt, e.busy_cnt);
`ifdef SHIFT_SEQ_FLAGS_EN
         chk("flag_Z", Z, (e.y == 16'h0000));
         chk("flag_N", N, e.y[15]);
`endif
      end
   endtask

   initial begin
      vec_t ab;
      bit   seen;

      //            op     amt    a         ci    y         c     gap noise
      vecs[0]  = '{2'b10, 4'd3,  16'h8001, 1'b1, 16'hF000, 1'b1, 1, 1'b0};
      vecs[1]  = '{2'b01, 4'd4,  16'h0001, 1'b0, 16'h1000, 1'b0, 2, 1'b0};
      vecs[2]  = '{2'b00, 4'd9,  16'h1234, 1'b0, 16'h1234, 1'b0, 0, 1'b0};
      vecs[3]  = '{2'b11, 4'd1,  16'h0001, 1'b0, 16'h0000, 1'b1, 1, 1'b0};
      vecs[4]  = '{2'b11, 4'd2,  16'h0001, 1'b0, 16'h8000, 1'b0, 1, 1'b0};
      vecs[5]  = '{2'b01, 4'd0,  16'hABCD, 1'b1, 16'hABCD, 1'b1, 0, 1'b0};
      vecs[6]  = '{2'b10, 4'd15, 16'h8000, 1'b0, 16'hFFFF, 1'b0, 1, 1'b0};
      vecs[7]  = '{2'b10, 4'd15, 16'h7FFF, 1'b1, 16'h0000, 1'b1, 0, 1'b0};
      vecs[8]  = '{2'b11, 4'd15, 16'h0000, 1'b1, 16'h0002, 1'b0, 1, 1'b0};
      vecs[9]  = '{2'b01, 4'd8,  16'h00FF, 1'b0, 16'hFF00, 1'b0, 1, 1'b1};
      vecs[10] = '{2'b01, 4'd15, 16'h8000, 1'b0, 16'h0001, 1'b0, 0, 1'b0};
      vecs[11] = '{2'b00, 4'd0,  16'h0000, 1'b1, 16'h0000, 1'b1, 0, 1'b0};

      rst    = 1'b1;
      start  = 1'b0;
      op     = 2'b00;
      amount = 4'd0;
      A      = 16'h0000;
      C_in   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset_Y", Y, 16'h0000);
      chk("reset_C_out", C_out, 1'b0);
      chk("reset_busy", busy, 1'b0);
      chk("reset_done", done, 1'b0);
`ifdef SHIFT_SEQ_FLAGS_EN
      chk("reset_Z", Z, 1'b1);
      chk("reset_N", N, 1'b0);
`endif

      for (int i = 0; i < NV; i++) begin
         for (int g = 0; g < vecs[i].gap; g++) begin
            @(posedge clk); #1;
            if (g == 0) chk("done_one_cycle", done, 1'b0);
         end
         run_op(vecs[i]);
      end

      // Abort: reset lands on the 5th shift edge of a long ASR.
      @(posedge clk); #1;
      ab = '{2'b10, 4'd15, 16'h8001, 1'b0, 16'h0000, 1'b0, 0, 1'b0};
      op     = ab.op;
      amount = ab.amt;
      A      = ab.a;
      C_in   = ab.ci;
      start  = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
      end
      chk("abort_mid_Y", Y, 16'hF800);
      chk("abort_mid_busy", busy, 1'b1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_Y", Y, 16'h0000);
      chk("abort_C_out", C_out, 1'b0);
      chk("abort_busy", busy, 1'b0);
      chk("abort_done", done, 1'b0);
      seen = 1'b0;
      repeat (20) begin
         @(posedge clk); #1;
         if (done) seen = 1'b1;
      end
      chk("abort_no_done", seen, 1'b0);
      chk("scoreboard_empty", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
